// File: rtl/tcp_framer.sv
// TCP segment framer: emits a 20-byte TCP header (no options) from latched fields,
// then passes the payload stream through unchanged until its last beat.
module tcp_framer (
  input  logic        clk,
  input  logic        sresetn,
  input  logic        hdr_i_valid,
  output logic        hdr_i_ready,
  input  logic [15:0] hdr_i_src_port,
  input  logic [15:0] hdr_i_dst_port,
  input  logic [31:0] hdr_i_seq_num,
  input  logic [31:0] hdr_i_ack_num,
  input  logic        hdr_i_ack,
  input  logic        hdr_i_rst,
  input  logic        hdr_i_syn,
  input  logic        hdr_i_fin,
  input  logic [15:0] hdr_i_window_size,
  input  logic [15:0] hdr_i_checksum,
  input  logic        hdr_i_no_payload,
  input  logic [31:0] axis_i_tdata,
  input  logic [3:0]  axis_i_tkeep,
  input  logic        axis_i_tvalid,
  output logic        axis_i_tready,
  input  logic        axis_i_tlast,
  output logic [31:0] axis_o_tdata,
  output logic [3:0]  axis_o_tkeep,
  output logic        axis_o_tvalid,
  input  logic        axis_o_tready,
  output logic        axis_o_tlast,
  output logic [1:0]  dbg_state
);

  localparam int AXIS_BYTES = 4;
  localparam int HDR_WORDS  = 5;

  // All handshakes: a transfer happens on the rising edge where valid and ready are
  // both high; a source holding valid keeps its data stable until that edge.
  typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, PAYLOAD = 2'd2} state_t;

  state_t      state, state_nxt;
  logic [2:0]  hdr_ctr, hdr_ctr_nxt;
  logic [15:0] src_q, dst_q, win_q, csum_q;
  logic [31:0] seq_q, ack_num_q;
  logic        ack_q, rst_q, syn_q, fin_q, no_pay_q;
  logic [31:0] hdr_word;
  logic        hdr_hs, out_hs, last_hdr;

  assign hdr_hs    = hdr_i_valid & hdr_i_ready;
  assign out_hs    = axis_o_tvalid & axis_o_tready;
  assign last_hdr  = (hdr_ctr == 3'(HDR_WORDS - 1));
  assign dbg_state = state;

  always_ff @(posedge clk or negedge sresetn) begin
    if (!sresetn) begin
      state   <= IDLE;
      hdr_ctr <= 3'd0;
    end else begin
      state   <= state_nxt;
      hdr_ctr <= hdr_ctr_nxt;
    end
  end

  always_ff @(posedge clk or negedge sresetn) begin
    if (!sresetn) begin
      src_q     <= '0;
      dst_q     <= '0;
      seq_q     <= '0;
      ack_num_q <= '0;
      ack_q     <= 1'b0;
      rst_q     <= 1'b0;
      syn_q     <= 1'b0;
      fin_q     <= 1'b0;
      win_q     <= '0;
      csum_q    <= '0;
      no_pay_q  <= 1'b0;
    end else if (hdr_hs) begin
      src_q     <= hdr_i_src_port;
      dst_q     <= hdr_i_dst_port;
      seq_q     <= hdr_i_seq_num;
      ack_num_q <= hdr_i_ack_num;
      ack_q     <= hdr_i_ack;
      rst_q     <= hdr_i_rst;
      syn_q     <= hdr_i_syn;
      fin_q     <= hdr_i_fin;
      win_q     <= hdr_i_window_size;
      csum_q    <= hdr_i_checksum;
      no_pay_q  <= hdr_i_no_payload;
    end
  end

  always_comb begin
    state_nxt   = state;
    hdr_ctr_nxt = hdr_ctr;
    case (state)
      IDLE: begin
        if (hdr_hs) begin
          state_nxt   = HDR;
          hdr_ctr_nxt = 3'd0;
        end
      end
      HDR: begin
        if (out_hs) begin
          if (last_hdr) begin
            hdr_ctr_nxt = 3'd0;
            state_nxt   = no_pay_q ? IDLE : PAYLOAD;
          end else begin
            hdr_ctr_nxt = hdr_ctr + 3'd1;
          end
        end
      end
      PAYLOAD: begin
        if (axis_i_tvalid && axis_o_tready && axis_i_tlast) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Network byte order: lane 0 carries the most significant byte of each field.
  always_comb begin
    hdr_word = '0;
    case (hdr_ctr)
      3'd0: hdr_word = {dst_q[7:0], dst_q[15:8], src_q[7:0], src_q[15:8]};
      3'd1: hdr_word = {seq_q[7:0], seq_q[15:8], seq_q[23:16], seq_q[31:24]};
      3'd2: hdr_word = {ack_num_q[7:0], ack_num_q[15:8], ack_num_q[23:16], ack_num_q[31:24]};
      3'd3: hdr_word = {win_q[7:0], win_q[15:8], 3'b000, ack_q, 1'b0, rst_q, syn_q, fin_q, 8'h50};
      3'd4: hdr_word = {16'h0000, csum_q[7:0], csum_q[15:8]};
      default: hdr_word = '0;
    endcase
  end

  always_comb begin
    hdr_i_ready   = 1'b0;
    axis_i_tready = 1'b0;
    axis_o_tvalid = 1'b0;
    axis_o_tdata  = '0;
    axis_o_tkeep  = '0;
    axis_o_tlast  = 1'b0;
    case (state)
      IDLE: hdr_i_ready = 1'b1;
      HDR: begin
        axis_o_tvalid = 1'b1;
        axis_o_tdata  = hdr_word;
        axis_o_tkeep  = {AXIS_BYTES{1'b1}};
        axis_o_tlast  = last_hdr & no_pay_q;
      end
      PAYLOAD: begin
        axis_o_tvalid = axis_i_tvalid;
        axis_o_tdata  = axis_i_tdata;
        axis_o_tkeep  = axis_i_tkeep;
        axis_o_tlast  = axis_i_tlast;
        axis_i_tready = axis_o_tready;
      end
      default: ;
    endcase
  end

endmodule
